// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port round-robin arbiter and fixed-latency access sequencer
//            in front of a single-port word memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_we,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_we,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic                  r_err;
    logic                  r_port;

    logic                  w_idle;
    logic                  w_hs0;
    logic                  w_hs1;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_read_ok;

    // A port wins when it is alone, or on contention when it was not granted last.
    assign w_idle     = (r_state == S_IDLE) && !rst;
    assign req0_ready = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign req1_ready = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign w_hs0      = req0_valid && req0_ready;
    assign w_hs1      = req1_valid && req1_ready;
    assign w_sel_addr = w_hs1 ? req1_addr : req0_addr;

    assign mem_addr    = r_addr;
    assign mem_data_in = r_wdata;
    // Reset gates the write strobe in the same cycle so an aborted access never writes.
    assign mem_we      = (r_state == S_ACCESS) && r_we && !r_err && !rst;
    assign w_read_ok   = !r_we && !r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_port       <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp0_rdata   <= '0;
            rsp0_err     <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_rdata   <= '0;
            rsp1_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs0 || w_hs1) begin
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_hs1 ? req1_wdata : req0_wdata;
                        r_we         <= w_hs1 ? req1_we : req0_we;
                        r_err        <= (w_sel_addr[1:0] != 2'b00);
                        r_port       <= w_hs1;
                        r_last_grant <= w_hs1;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rsp0_valid <= !r_port;
                    rsp0_rdata <= (!r_port && w_read_ok) ? mem_data_out : '0;
                    rsp0_err   <= !r_port && r_err;
                    rsp1_valid <= r_port;
                    rsp1_rdata <= (r_port && w_read_ok) ? mem_data_out : '0;
                    rsp1_err   <= r_port && r_err;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp0_rdata <= '0;
                    rsp0_err   <= 1'b0;
                    rsp1_valid <= 1'b0;
                    rsp1_rdata <= '0;
                    rsp1_err   <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
